// File: rtl/charram_dram_ctrl_if.sv
// CPU, video and DRAM signal bundle for the character-RAM DRAM controller.
// The controller attaches through the slave modport; the surrounding system uses master.
interface charram_dram_ctrl_if;
  logic [13:0] i_VID_ADDR;
  logic        i_CPU_REQ;
  logic        i_CPU_RW;
  logic [13:0] i_CPU_ADDR;
  logic [3:0]  i_CPU_DIN;
  logic [3:0]  i_DRAM_DOUT;
  logic [7:0]  o_ADDR;
  logic        o_RAS_n;
  logic        o_CAS_n;
  logic        o_WR_n;
  logic        o_RD_n;
  logic [3:0]  o_DIN;
  logic        o_DTACK_n;
  logic [3:0]  o_CPU_DOUT;
  logic [3:0]  o_PX_DOUT;
  logic        o_PX_VALID;
  logic [2:0]  o_PHASE;
  logic        o_SLOT;

  modport slave (
    input  i_VID_ADDR, i_CPU_REQ, i_CPU_RW, i_CPU_ADDR, i_CPU_DIN, i_DRAM_DOUT,
    output o_ADDR, o_RAS_n, o_CAS_n, o_WR_n, o_RD_n, o_DIN, o_DTACK_n,
           o_CPU_DOUT, o_PX_DOUT, o_PX_VALID, o_PHASE, o_SLOT
  );

  modport master (
    output i_VID_ADDR, i_CPU_REQ, i_CPU_RW, i_CPU_ADDR, i_CPU_DIN, i_DRAM_DOUT,
    input  o_ADDR, o_RAS_n, o_CAS_n, o_WR_n, o_RD_n, o_DIN, o_DTACK_n,
           o_CPU_DOUT, o_PX_DOUT, o_PX_VALID, o_PHASE, o_SLOT
  );
endinterface

// File: rtl/charram_dram_ctrl.sv
// Time-sliced 4416 DRAM controller: alternating 8-phase video and CPU slots,
// with RAS-only refresh filling CPU slots that carry no request.
module charram_dram_ctrl #(
  parameter int SLOT_LEN = 8
) (
  input logic               i_MCLK,
  input logic               i_RST_n,
  charram_dram_ctrl_if.slave bus
);

  if (SLOT_LEN != 8) begin : g_slot_len_chk
    $error("charram_dram_ctrl supports only SLOT_LEN = 8");
  end

  logic [2:0]  phase, nphase;
  logic        slot, nslot;
  logic [13:0] vid_addr, vid_addr_d;
  logic [13:0] cpu_addr, cpu_addr_d;
  logic        cpu_rw, cpu_rw_d;
  logic [3:0]  cpu_data, cpu_data_d;
  logic        cpu_act, cpu_act_d;
  logic [7:0]  rfsh, rfsh_d;
  logic        dtack_n;
  logic [13:0] act_addr;
  logic        refresh, cpu_rd, cpu_wr;
  logic [7:0]  addr_d, addr_q;
  logic        ras_d, cas_d, rd_d, wr_d;
  logic        ras_q, cas_q, rd_q, wr_q;
  logic [3:0]  din_d, din_q;
  logic [3:0]  cpu_dout, px_dout;
  logic        px_valid;

  // Strobes are registered from the next phase so they line up with o_PHASE.
  always_comb begin
    nphase     = phase + 3'd1;
    nslot      = (phase == 3'd7) ? ~slot : slot;
    vid_addr_d = vid_addr;
    cpu_addr_d = cpu_addr;
    cpu_rw_d   = cpu_rw;
    cpu_data_d = cpu_data;
    cpu_act_d  = cpu_act;
    rfsh_d     = rfsh;
    if (phase == 3'd7) begin
      if (slot) begin
        vid_addr_d = bus.i_VID_ADDR;
        cpu_act_d  = 1'b0;
        if (!cpu_act) rfsh_d = rfsh + 8'd1;
      end else if (bus.i_CPU_REQ && dtack_n) begin
        cpu_act_d  = 1'b1;
        cpu_addr_d = bus.i_CPU_ADDR;
        cpu_rw_d   = bus.i_CPU_RW;
        cpu_data_d = bus.i_CPU_DIN;
      end
    end

    refresh  = nslot && !cpu_act_d;
    cpu_rd   = nslot && cpu_act_d && cpu_rw_d;
    cpu_wr   = nslot && cpu_act_d && !cpu_rw_d;
    act_addr = !nslot ? vid_addr_d : (cpu_act_d ? cpu_addr_d : {6'd0, rfsh_d});

    ras_d  = !((nphase >= 3'd1) && (nphase <= 3'd5));
    cas_d  = !(((nphase == 3'd3) || (nphase == 3'd4)) && !refresh);
    addr_d = ((nphase == 3'd3) || (nphase == 3'd4)) ? {1'b0, act_addr[13:8], 1'b0}
                                                    : act_addr[7:0];
    rd_d   = !((nphase == 3'd4) && (!nslot || cpu_rd));
    wr_d   = !((nphase == 3'd4) && cpu_wr);
    din_d  = (cpu_wr && (nphase >= 3'd3) && (nphase <= 3'd5)) ? cpu_data_d : 4'd0;
  end

  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      phase    <= 3'd0;
      slot     <= 1'b0;
      vid_addr <= 14'd0;
      cpu_addr <= 14'd0;
      cpu_rw   <= 1'b1;
      cpu_data <= 4'd0;
      cpu_act  <= 1'b0;
      rfsh     <= 8'd0;
      dtack_n  <= 1'b1;
      addr_q   <= 8'd0;
      ras_q    <= 1'b1;
      cas_q    <= 1'b1;
      rd_q     <= 1'b1;
      wr_q     <= 1'b1;
      din_q    <= 4'd0;
      cpu_dout <= 4'd0;
      px_dout  <= 4'd0;
      px_valid <= 1'b0;
    end else begin
      phase    <= nphase;
      slot     <= nslot;
      vid_addr <= vid_addr_d;
      cpu_addr <= cpu_addr_d;
      cpu_rw   <= cpu_rw_d;
      cpu_data <= cpu_data_d;
      cpu_act  <= cpu_act_d;
      rfsh     <= rfsh_d;
      addr_q   <= addr_d;
      ras_q    <= ras_d;
      cas_q    <= cas_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      din_q    <= din_d;
      px_valid <= (nphase == 3'd6) && !nslot;
      // DRAM read data is registered by the part, so it is valid during p5.
      if ((phase == 3'd5) && !slot) px_dout <= bus.i_DRAM_DOUT;
      if ((phase == 3'd5) && slot && cpu_act && cpu_rw) cpu_dout <= bus.i_DRAM_DOUT;
      // Acknowledge holds until the CPU withdraws its request.
      if ((nphase == 3'd6) && nslot && cpu_act_d) dtack_n <= 1'b0;
      else if (!dtack_n && !bus.i_CPU_REQ)        dtack_n <= 1'b1;
    end
  end

  assign bus.o_PHASE    = phase;
  assign bus.o_SLOT     = slot;
  assign bus.o_ADDR     = addr_q;
  assign bus.o_RAS_n    = ras_q;
  assign bus.o_CAS_n    = cas_q;
  assign bus.o_RD_n     = rd_q;
  assign bus.o_WR_n     = wr_q;
  assign bus.o_DIN      = din_q;
  assign bus.o_DTACK_n  = dtack_n;
  assign bus.o_CPU_DOUT = cpu_dout;
  assign bus.o_PX_DOUT  = px_dout;
  assign bus.o_PX_VALID = px_valid;

endmodule

// File: tb/tb_charram_dram_ctrl.sv
// Directed bench for charram_dram_ctrl with a behavioural 4416 DRAM model.
module tb_charram_dram_ctrl;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  charram_dram_ctrl_if bus ();

  charram_dram_ctrl dut (
    .i_MCLK (clk),
    .i_RST_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 4416 model: row latched on RAS fall, column on CAS low, registered read data.
  logic [3:0] mem [0:16383];
  logic [7:0] row_q;
  logic       ras_prev;
  always @(posedge clk) begin
    if (!bus.o_RAS_n && ras_prev) row_q <= bus.o_ADDR;
    ras_prev <= bus.o_RAS_n;
    if (!bus.o_CAS_n && !bus.o_WR_n) mem[{bus.o_ADDR[6:1], row_q}] <= bus.o_DIN;
    if (!bus.o_CAS_n && !bus.o_RD_n) bus.i_DRAM_DOUT <= mem[{bus.o_ADDR[6:1], row_q}];
  end

  // Strobe legality across the whole run.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ((!bus.o_RD_n && !bus.o_WR_n) || (bus.o_CAS_n && (!bus.o_RD_n || !bus.o_WR_n))) begin
        failures++;
        $display("FAIL strobe_legal rd_n=%b wr_n=%b cas_n=%b", bus.o_RD_n, bus.o_WR_n, bus.o_CAS_n);
      end
    end
  end

  task automatic poke(input logic [13:0] a, input logic [3:0] v);
    mem[a] <= v;
  endtask

  task automatic wait_phase(input logic [2:0] p, input logic s);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.o_PHASE == p && bus.o_SLOT == s) && n < 40);
    if (!(bus.o_PHASE == p && bus.o_SLOT == s)) begin
      checks++;
      failures++;
      $display("FAIL wait_phase got=%0d/%0d want=%0d/%0d", bus.o_PHASE, bus.o_SLOT, p, s);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.o_PHASE !== 3'd0) begin failures++; $display("FAIL rst_phase got=%h want=0", bus.o_PHASE); end
    checks++; if (bus.o_SLOT !== 1'b0) begin failures++; $display("FAIL rst_slot got=%b want=0", bus.o_SLOT); end
    checks++; if ({bus.o_RAS_n, bus.o_CAS_n, bus.o_RD_n, bus.o_WR_n, bus.o_DTACK_n} !== 5'b11111) begin
      failures++; $display("FAIL rst_strobes got=%b want=11111", {bus.o_RAS_n, bus.o_CAS_n, bus.o_RD_n, bus.o_WR_n, bus.o_DTACK_n}); end
    checks++; if (bus.o_ADDR !== 8'h00) begin failures++; $display("FAIL rst_addr got=%h want=00", bus.o_ADDR); end
    checks++; if ({bus.o_DIN, bus.o_CPU_DOUT, bus.o_PX_DOUT} !== 12'h000) begin
      failures++; $display("FAIL rst_data got=%h want=000", {bus.o_DIN, bus.o_CPU_DOUT, bus.o_PX_DOUT}); end
    checks++; if (bus.o_PX_VALID !== 1'b0) begin failures++; $display("FAIL rst_pxvalid got=%b want=0", bus.o_PX_VALID); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({bus.o_SLOT, bus.o_PHASE} !== 4'b0001) begin
      failures++; $display("FAIL rst_first_edge got=%b want=0001", {bus.o_SLOT, bus.o_PHASE}); end
  endtask

  task automatic test_refresh();
    int cas_low = 0;
    int strobe_low = 0;
    for (int k = 0; k < 257; k++) begin
      wait_phase(3'd1, 1'b1);
      checks++;
      if (bus.o_ADDR !== k[7:0]) begin
        failures++; $display("FAIL refresh_row slot=%0d got=%h want=%h", k, bus.o_ADDR, k[7:0]);
      end
      for (int p = 2; p < 8; p++) begin
        @(negedge clk);
        if (!bus.o_CAS_n) cas_low++;
        if (!bus.o_RD_n || !bus.o_WR_n) strobe_low++;
      end
    end
    checks++; if (cas_low !== 0) begin failures++; $display("FAIL refresh_cas got=%0d want=0", cas_low); end
    checks++; if (strobe_low !== 0) begin failures++; $display("FAIL refresh_rdwr got=%0d want=0", strobe_low); end
  endtask

  task automatic test_video_fetch();
    poke(14'h2A5C, 4'h9);
    bus.i_VID_ADDR = 14'h2A5C;
    wait_phase(3'd7, 1'b1);
    wait_phase(3'd0, 1'b0);
    checks++; if (bus.o_ADDR !== 8'h5C) begin failures++; $display("FAIL vid_p0_addr got=%h want=5C", bus.o_ADDR); end
    wait_phase(3'd1, 1'b0);
    bus.i_VID_ADDR = 14'h0011;
    checks++; if ({bus.o_ADDR, bus.o_RAS_n, bus.o_CAS_n} !== {8'h5C, 2'b01}) begin
      failures++; $display("FAIL vid_p1 got=%h want=%h", {bus.o_ADDR, bus.o_RAS_n, bus.o_CAS_n}, {8'h5C, 2'b01}); end
    wait_phase(3'd2, 1'b0);
    checks++; if (bus.o_ADDR !== 8'h5C) begin failures++; $display("FAIL vid_p2_addr got=%h want=5C", bus.o_ADDR); end
    wait_phase(3'd3, 1'b0);
    checks++; if ({bus.o_ADDR, bus.o_CAS_n, bus.o_RD_n} !== {8'h54, 2'b01}) begin
      failures++; $display("FAIL vid_p3 got=%h want=%h", {bus.o_ADDR, bus.o_CAS_n, bus.o_RD_n}, {8'h54, 2'b01}); end
    wait_phase(3'd4, 1'b0);
    checks++; if ({bus.o_ADDR, bus.o_RD_n, bus.o_WR_n} !== {8'h54, 2'b01}) begin
      failures++; $display("FAIL vid_p4 got=%h want=%h", {bus.o_ADDR, bus.o_RD_n, bus.o_WR_n}, {8'h54, 2'b01}); end
    wait_phase(3'd5, 1'b0);
    checks++; if ({bus.o_ADDR, bus.o_RAS_n, bus.o_CAS_n, bus.o_RD_n, bus.o_PX_VALID} !== {8'h5C, 4'b0110}) begin
      failures++; $display("FAIL vid_p5 got=%h", {bus.o_ADDR, bus.o_RAS_n, bus.o_CAS_n, bus.o_RD_n, bus.o_PX_VALID}); end
    wait_phase(3'd6, 1'b0);
    checks++; if ({bus.o_PX_DOUT, bus.o_PX_VALID, bus.o_RAS_n} !== {4'h9, 2'b11}) begin
      failures++; $display("FAIL vid_p6 got=%h want=%h", {bus.o_PX_DOUT, bus.o_PX_VALID, bus.o_RAS_n}, {4'h9, 2'b11}); end
    wait_phase(3'd7, 1'b0);
    checks++; if (bus.o_PX_VALID !== 1'b0) begin failures++; $display("FAIL vid_p7_valid got=%b want=0", bus.o_PX_VALID); end
  endtask

  task automatic test_cpu_write();
    poke(14'h3FFF, 4'h3);
    wait_phase(3'd6, 1'b0);
    bus.i_CPU_REQ = 1'b1; bus.i_CPU_RW = 1'b0; bus.i_CPU_ADDR = 14'h3FFF; bus.i_CPU_DIN = 4'hA;
    wait_phase(3'd1, 1'b1);
    bus.i_CPU_ADDR = 14'h0000; bus.i_CPU_DIN = 4'h0;
    checks++; if (bus.o_ADDR !== 8'hFF) begin failures++; $display("FAIL wr_row got=%h want=FF", bus.o_ADDR); end
    wait_phase(3'd3, 1'b1);
    checks++; if ({bus.o_ADDR, bus.o_DIN, bus.o_CAS_n, bus.o_WR_n} !== {8'h7E, 4'hA, 2'b01}) begin
      failures++; $display("FAIL wr_p3 got=%h want=%h", {bus.o_ADDR, bus.o_DIN, bus.o_CAS_n, bus.o_WR_n}, {8'h7E, 4'hA, 2'b01}); end
    wait_phase(3'd4, 1'b1);
    checks++; if ({bus.o_DIN, bus.o_WR_n, bus.o_RD_n} !== {4'hA, 2'b01}) begin
      failures++; $display("FAIL wr_p4 got=%h want=%h", {bus.o_DIN, bus.o_WR_n, bus.o_RD_n}, {4'hA, 2'b01}); end
    wait_phase(3'd5, 1'b1);
    checks++; if ({bus.o_DIN, bus.o_WR_n, bus.o_DTACK_n} !== {4'hA, 2'b11}) begin
      failures++; $display("FAIL wr_p5 got=%h want=%h", {bus.o_DIN, bus.o_WR_n, bus.o_DTACK_n}, {4'hA, 2'b11}); end
    wait_phase(3'd6, 1'b1);
    checks++; if (bus.o_DTACK_n !== 1'b0) begin failures++; $display("FAIL wr_dtack_p6 got=%b want=0", bus.o_DTACK_n); end
    wait_phase(3'd2, 1'b0);
    checks++; if (bus.o_DTACK_n !== 1'b0) begin failures++; $display("FAIL wr_dtack_hold got=%b want=0", bus.o_DTACK_n); end
    bus.i_CPU_REQ = 1'b0;
    @(negedge clk);
    checks++; if (bus.o_DTACK_n !== 1'b1) begin failures++; $display("FAIL wr_dtack_release got=%b want=1", bus.o_DTACK_n); end
    checks++; if (mem[14'h3FFF] !== 4'hA) begin failures++; $display("FAIL wr_mem got=%h want=A", mem[14'h3FFF]); end
    wait_phase(3'd3, 1'b1);
    checks++; if (bus.o_CAS_n !== 1'b1) begin failures++; $display("FAIL wr_no_repeat got=%b want=1", bus.o_CAS_n); end
  endtask

  task automatic test_back_to_back();
    poke(14'h0123, 4'h5);
    poke(14'h0456, 4'h1);
    wait_phase(3'd6, 1'b0);
    bus.i_CPU_REQ = 1'b1; bus.i_CPU_RW = 1'b1; bus.i_CPU_ADDR = 14'h0123;
    wait_phase(3'd4, 1'b1);
    checks++; if ({bus.o_ADDR, bus.o_RD_n, bus.o_WR_n} !== {8'h02, 2'b01}) begin
      failures++; $display("FAIL b2b_rd_p4 got=%h want=%h", {bus.o_ADDR, bus.o_RD_n, bus.o_WR_n}, {8'h02, 2'b01}); end
    wait_phase(3'd6, 1'b1);
    checks++; if ({bus.o_CPU_DOUT, bus.o_DTACK_n} !== {4'h5, 1'b0}) begin
      failures++; $display("FAIL b2b_rd_data got=%h want=%h", {bus.o_CPU_DOUT, bus.o_DTACK_n}, {4'h5, 1'b0}); end
    bus.i_CPU_RW = 1'b0; bus.i_CPU_ADDR = 14'h0456; bus.i_CPU_DIN = 4'h7;
    wait_phase(3'd1, 1'b1);
    checks++; if (bus.o_DTACK_n !== 1'b0) begin failures++; $display("FAIL b2b_dtack_held got=%b want=0", bus.o_DTACK_n); end
    wait_phase(3'd3, 1'b1);
    checks++; if (bus.o_CAS_n !== 1'b1) begin failures++; $display("FAIL b2b_not_taken got=%b want=1", bus.o_CAS_n); end
    wait_phase(3'd4, 1'b1);
    bus.i_CPU_REQ = 1'b0;
    @(negedge clk);
    checks++; if (bus.o_DTACK_n !== 1'b1) begin failures++; $display("FAIL b2b_release got=%b want=1", bus.o_DTACK_n); end
    wait_phase(3'd6, 1'b0);
    bus.i_CPU_REQ = 1'b1;
    wait_phase(3'd4, 1'b1);
    checks++; if ({bus.o_ADDR, bus.o_WR_n, bus.o_DIN} !== {8'h08, 1'b0, 4'h7}) begin
      failures++; $display("FAIL b2b_wr_p4 got=%h want=%h", {bus.o_ADDR, bus.o_WR_n, bus.o_DIN}, {8'h08, 1'b0, 4'h7}); end
    wait_phase(3'd6, 1'b1);
    bus.i_CPU_REQ = 1'b0;
    checks++; if (bus.o_DTACK_n !== 1'b0) begin failures++; $display("FAIL b2b_wr_dtack got=%b want=0", bus.o_DTACK_n); end
    @(negedge clk);
    checks++; if (bus.o_DTACK_n !== 1'b1) begin failures++; $display("FAIL b2b_wr_release got=%b want=1", bus.o_DTACK_n); end
    checks++; if (mem[14'h0456] !== 4'h7) begin failures++; $display("FAIL b2b_wr_mem got=%h want=7", mem[14'h0456]); end
  endtask

  task automatic test_reset_mid_write();
    poke(14'h1234, 4'h2);
    wait_phase(3'd6, 1'b0);
    bus.i_CPU_REQ = 1'b1; bus.i_CPU_RW = 1'b0; bus.i_CPU_ADDR = 14'h1234; bus.i_CPU_DIN = 4'hF;
    wait_phase(3'd3, 1'b1);
    #1;
    rst_n = 1'b0;
    bus.i_CPU_REQ = 1'b0;
    #1;
    checks++; if ({bus.o_WR_n, bus.o_DTACK_n, bus.o_RAS_n, bus.o_CAS_n} !== 4'b1111) begin
      failures++; $display("FAIL rstw_strobes got=%b want=1111", {bus.o_WR_n, bus.o_DTACK_n, bus.o_RAS_n, bus.o_CAS_n}); end
    checks++; if ({bus.o_SLOT, bus.o_PHASE} !== 4'b0000) begin
      failures++; $display("FAIL rstw_phase got=%b want=0000", {bus.o_SLOT, bus.o_PHASE}); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (mem[14'h1234] !== 4'h2) begin failures++; $display("FAIL rstw_mem got=%h want=2", mem[14'h1234]); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.i_VID_ADDR = 14'd0;
    bus.i_CPU_REQ  = 1'b0;
    bus.i_CPU_RW   = 1'b1;
    bus.i_CPU_ADDR = 14'd0;
    bus.i_CPU_DIN  = 4'd0;
    for (int i = 0; i < 16384; i++) mem[i] <= 4'd0;
    test_reset();
    test_refresh();
    test_video_fetch();
    test_cpu_write();
    test_back_to_back();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
